// File: rtl/button_event.sv
// button_event: turns a debounced button level into press, release,
// short, long and double-click pulses for the mode and menu FSMs.
module button_event #(
    parameter int LONG_CYCLES   = 100,
    parameter int DCLICK_CYCLES = 30,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_db,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_press,
    output logic       long_press,
    output logic       double_click,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_PRESSED     = 3'd1,
        S_LONG_HELD   = 3'd2,
        S_WAIT_SECOND = 3'd3,
        S_SECOND_PRS  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             r_btn_prev;
    logic             w_rise;
    logic             w_fall;
    logic             w_short_nx;
    logic             w_long_nx;
    logic             w_dclick_nx;

    assign w_rise  = btn_db & ~r_btn_prev;
    assign w_fall  = ~btn_db & r_btn_prev;
    assign state_o = r_state;

    // Next-state, counter and gesture pulse decode; a button sample
    // always wins over a timeout compare on the same edge.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_short_nx  = 1'b0;
        w_long_nx   = 1'b0;
        w_dclick_nx = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nx = S_PRESSED;
                    w_cnt_nx   = CNT_ONE;
                end
            end
            S_PRESSED: begin
                if (!btn_db) begin
                    w_state_nx = S_WAIT_SECOND;
                    w_cnt_nx   = CNT_ONE;
                end else if (r_cnt == LONG_LAST) begin
                    w_state_nx = S_LONG_HELD;
                    w_long_nx  = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + CNT_ONE;
                end
            end
            S_LONG_HELD: begin
                if (!btn_db) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end
            end
            S_WAIT_SECOND: begin
                if (btn_db) begin
                    w_state_nx  = S_SECOND_PRS;
                    w_cnt_nx    = '0;
                    w_dclick_nx = 1'b1;
                end else if (r_cnt == DCLICK_LAST) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                    w_short_nx = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + CNT_ONE;
                end
            end
            S_SECOND_PRS: begin
                if (!btn_db) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // State, counter, edge history and registered output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_btn_prev    <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            double_click  <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_btn_prev    <= btn_db;
            press_pulse   <= w_rise;
            release_pulse <= w_fall;
            short_press   <= w_short_nx;
            long_press    <= w_long_nx;
            double_click  <= w_dclick_nx;
        end
    end

endmodule

// File: tb/tb_button_event.sv
// tb_button_event: directed gesture vectors for button_event with
// LONG_CYCLES=8 and DCLICK_CYCLES=4, hand-computed expectations.
module tb_button_event;

    logic       clk;
    logic       rst;
    logic       btn_db;
    logic       press_pulse;
    logic       release_pulse;
    logic       short_press;
    logic       long_press;
    logic       double_click;
    logic [2:0] state_o;

    int checks;
    int failures;

    // Event vector order: {press, release, short, long, dclick}.
    logic [4:0] w_ev;
    assign w_ev = {press_pulse, release_pulse, short_press,
                   long_press, double_click};

    button_event #(
        .LONG_CYCLES  (8),
        .DCLICK_CYCLES(4),
        .CNT_W        (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_db       (btn_db),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one sample, then observe just after the edge that took it.
    task automatic cyc(input logic b);
        btn_db = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        btn_db = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(logic'(i % 2 == 0));
            checks++;
            if (w_ev !== 5'b00000) begin
                failures++;
                $display("FAIL reset_ev step=%0d got=%b exp=%b",
                         i, w_ev, 5'b00000);
            end
            checks++;
            if (state_o !== 3'd0) begin
                failures++;
                $display("FAIL reset_state step=%0d got=%0d exp=0",
                         i, state_o);
            end
        end
        rst = 1'b0;
        cyc(1'b1);
        checks++;
        if (w_ev !== 5'b10000 || state_o !== 3'd1) begin
            failures++;
            $display("FAIL reset_release got=%b/%0d exp=10000/1",
                     w_ev, state_o);
        end
        cyc(1'b1);
        checks++;
        if (w_ev !== 5'b00000 || state_o !== 3'd1) begin
            failures++;
            $display("FAIL reset_release_next got=%b/%0d exp=00000/1",
                     w_ev, state_o);
        end
    endtask

    task automatic test_short_press();
        logic       ins [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
        logic [4:0] ev  [8] = '{5'b10000, 5'b00000, 5'b00000, 5'b01000,
                                5'b00000, 5'b00000, 5'b00100, 5'b00000};
        logic [2:0] st  [8] = '{3'd1, 3'd1, 3'd1, 3'd3,
                                3'd3, 3'd3, 3'd0, 3'd0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(ins[i]);
            checks++;
            if (w_ev !== ev[i] || state_o !== st[i]) begin
                failures++;
                $display("FAIL short step=%0d got=%b/%0d exp=%b/%0d",
                         i, w_ev, state_o, ev[i], st[i]);
            end
        end
    endtask

    task automatic test_long_press();
        logic [4:0] ev;
        logic [2:0] st;
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b1);
            ev = (i == 1) ? 5'b10000 : (i == 8) ? 5'b00010 : 5'b00000;
            st = (i < 8) ? 3'd1 : 3'd2;
            checks++;
            if (w_ev !== ev || state_o !== st) begin
                failures++;
                $display("FAIL long_hold step=%0d got=%b/%0d exp=%b/%0d",
                         i, w_ev, state_o, ev, st);
            end
        end
        cyc(1'b0);
        checks++;
        if (w_ev !== 5'b01000 || state_o !== 3'd0) begin
            failures++;
            $display("FAIL long_release got=%b/%0d exp=01000/0",
                     w_ev, state_o);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0);
            checks++;
            if (w_ev !== 5'b00000 || state_o !== 3'd0) begin
                failures++;
                $display("FAIL long_after step=%0d got=%b/%0d exp=00000/0",
                         i, w_ev, state_o);
            end
        end
    endtask

    task automatic test_double_click();
        logic       ins [12] = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        logic [4:0] ev  [12] = '{5'b10000, 5'b00000, 5'b01000, 5'b00000,
                                 5'b10001, 5'b00000, 5'b01000, 5'b00000,
                                 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        logic [2:0] st  [12] = '{3'd1, 3'd1, 3'd3, 3'd3, 3'd4, 3'd4,
                                 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cyc(ins[i]);
            checks++;
            if (w_ev !== ev[i] || state_o !== st[i]) begin
                failures++;
                $display("FAIL dclick step=%0d got=%b/%0d exp=%b/%0d",
                         i, w_ev, state_o, ev[i], st[i]);
            end
        end
    endtask

    task automatic test_window_boundary();
        logic       ia [6] = '{1, 0, 0, 0, 1, 0};
        logic [4:0] ea [6] = '{5'b10000, 5'b01000, 5'b00000, 5'b00000,
                               5'b10001, 5'b01000};
        logic [2:0] sa [6] = '{3'd1, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
        logic       ib [10] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        logic [4:0] eb [10] = '{5'b10000, 5'b01000, 5'b00000, 5'b00000,
                                5'b00100, 5'b10000, 5'b01000, 5'b00000,
                                5'b00000, 5'b00100};
        logic [2:0] sb [10] = '{3'd1, 3'd3, 3'd3, 3'd3, 3'd0,
                                3'd1, 3'd3, 3'd3, 3'd3, 3'd0};
        logic       ic [12] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        logic [4:0] ec [12] = '{5'b10000, 5'b00000, 5'b00000, 5'b00000,
                                5'b00000, 5'b00000, 5'b00000, 5'b01000,
                                5'b00000, 5'b00000, 5'b00100, 5'b00000};
        logic [2:0] sc [12] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1,
                                3'd1, 3'd3, 3'd3, 3'd3, 3'd0, 3'd0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(ia[i]);
            checks++;
            if (w_ev !== ea[i] || state_o !== sa[i]) begin
                failures++;
                $display("FAIL win_low3 step=%0d got=%b/%0d exp=%b/%0d",
                         i, w_ev, state_o, ea[i], sa[i]);
            end
        end
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(ib[i]);
            checks++;
            if (w_ev !== eb[i] || state_o !== sb[i]) begin
                failures++;
                $display("FAIL win_low4 step=%0d got=%b/%0d exp=%b/%0d",
                         i, w_ev, state_o, eb[i], sb[i]);
            end
        end
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cyc(ic[i]);
            checks++;
            if (w_ev !== ec[i] || state_o !== sc[i]) begin
                failures++;
                $display("FAIL win_high7 step=%0d got=%b/%0d exp=%b/%0d",
                         i, w_ev, state_o, ec[i], sc[i]);
            end
        end
    endtask

    task automatic test_reset_mid_window();
        do_reset();
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b0);
        checks++;
        if (state_o !== 3'd3) begin
            failures++;
            $display("FAIL midwin_pre got=%0d exp=3", state_o);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (w_ev !== 5'b00000 || state_o !== 3'd0) begin
            failures++;
            $display("FAIL midwin_async got=%b/%0d exp=00000/0",
                     w_ev, state_o);
        end
        cyc(1'b0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0);
            checks++;
            if (w_ev !== 5'b00000 || state_o !== 3'd0) begin
                failures++;
                $display("FAIL midwin_after step=%0d got=%b/%0d exp=00000/0",
                         i, w_ev, state_o);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        btn_db   = 1'b0;
        test_reset();
        test_short_press();
        test_long_press();
        test_double_click();
        test_window_boundary();
        test_reset_mid_window();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
